// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NREQ
// valid/ready producers, holding the grant across a burst of up to MAX_BURST beats.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 248,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NREQ-1:0]           i_req_valid,
   input  logic [NREQ-1:0]           i_req_last,
   input  logic [NREQ*WIDTH-1:0]     i_req_data,
   output logic [NREQ-1:0]           o_req_ready,
   output logic                      o_fifo_write,
   output logic [WIDTH-1:0]          o_fifo_data,
   input  logic                      i_fifo_full,
   output logic [$clog2(NREQ)-1:0]   o_grant_id,
   output logic                      o_locked
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST) + 1;

   logic          locked_q, locked_d;
   logic [IW-1:0] owner_q, owner_d, last_grant_q, last_grant_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic [IW-1:0] rr_grant, grant, idx;
   logic          found, xfer, eob;

   // Search upward from the requester after the last burst winner, wrapping.
   always_comb begin
      found    = 1'b0;
      rr_grant = '0;
      idx      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last_grant_q) + k) % NREQ);
         if (!found && i_req_valid[idx]) begin
            found    = 1'b1;
            rr_grant = idx;
         end
      end
   end

   assign grant        = locked_q ? owner_q : rr_grant;
   assign o_fifo_write = rstn & (locked_q | found) & i_req_valid[grant];
   assign o_fifo_data  = i_req_data[grant*WIDTH +: WIDTH];
   assign xfer         = o_fifo_write & ~i_fifo_full;
   assign o_req_ready  = xfer ? (NREQ'(1) << grant) : '0;
   assign eob          = i_req_last[grant] | (beat_cnt_q == CW'(MAX_BURST - 1));
   assign o_grant_id   = rstn ? grant : '0;
   assign o_locked     = locked_q;

   always_comb begin
      locked_d     = xfer ? ~eob : locked_q;
      owner_d      = (xfer & ~eob) ? grant : owner_q;
      last_grant_d = (xfer & eob) ? grant : last_grant_q;
      beat_cnt_d   = xfer ? (eob ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         locked_q     <= 1'b0;
         owner_q      <= '0;
         last_grant_q <= IW'(NREQ - 1);
         beat_cnt_q   <= '0;
      end else begin
         locked_q     <= locked_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench; expected beats are queued in arbitration
// order as stimulus is loaded and popped on every accepted FIFO write.
module tb_fifo_wr_arbiter;
   localparam int W  = 248;
   localparam int N  = 4;
   localparam int MB = 8;

   logic          clk = 1'b0, rstn = 1'b0;
   logic [N-1:0]  i_req_valid = '0, i_req_last = '0;
   logic [N*W-1:0] i_req_data = '0;
   logic [N-1:0]  o_req_ready;
   logic          o_fifo_write;
   logic [W-1:0]  o_fifo_data;
   logic          i_fifo_full = 1'b0;
   logic [1:0]    o_grant_id;
   logic          o_locked;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(MB)) dut (
      .clk(clk), .rstn(rstn),
      .i_req_valid(i_req_valid), .i_req_last(i_req_last), .i_req_data(i_req_data),
      .o_req_ready(o_req_ready),
      .o_fifo_write(o_fifo_write), .o_fifo_data(o_fifo_data), .i_fifo_full(i_fifo_full),
      .o_grant_id(o_grant_id), .o_locked(o_locked)
   );

   typedef struct {int id; logic [W-1:0] d; logic lk;} ex_t;
   ex_t          exq[$];
   logic [W-1:0] bd[N][32];
   logic         bl[N][32];
   int           bn[N], bp[N];
   logic         stall[N];
   int           n_tests = 0, n_fail = 0, nw = 0, cycles = 0;
   logic         lk_pend = 1'b0, lk_exp = 1'b0;

   function automatic logic [W-1:0] mk(int r, int k);
      return {8'(r), 16'(k), {7{32'hA5C3_0F00 ^ 32'(r * 64 + k)}}};
   endfunction

   task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pkt(int r, int n);
      for (int j = 0; j < n; j++) begin
         bd[r][bn[r]] = mk(r, bn[r]);
         bl[r][bn[r]] = (j == n - 1);
         bn[r]++;
      end
   endtask

   task automatic expect_beat(int r, int k, logic lk);
      exq.push_back('{r, mk(r, k), lk});
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         logic v;
         v = (bp[i] < bn[i]) && !stall[i];
         i_req_valid[i]         = v;
         i_req_last[i]          = v ? bl[i][bp[i]] : 1'b0;
         i_req_data[i*W +: W]   = v ? bd[i][bp[i]] : '0;
      end
   endtask

   // Lock flag is checked one cycle after the beat that should set or clear it.
   task automatic mon();
      ex_t e;
      @(negedge clk);
      if (lk_pend) begin
         check("lock_after_beat", 256'(o_locked), 256'(lk_exp));
         lk_pend = 1'b0;
      end
      if (o_fifo_write && !i_fifo_full) begin
         if (exq.size() == 0) check("sb_empty", 256'(exq.size()), 256'(1));
         else begin
            e = exq.pop_front();
            check("grant", 256'(o_grant_id), 256'(e.id));
            check("data", 256'(o_fifo_data), 256'(e.d));
            check("ready", 256'(o_req_ready), 256'(1 << e.id));
            lk_pend = 1'b1;
            lk_exp  = e.lk;
         end
         for (int i = 0; i < N; i++) if (o_req_ready[i]) bp[i]++;
         nw++;
      end else check("ready_idle", 256'(o_req_ready), 256'(0));
   endtask

   task automatic cyc();
      mon();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_writes(int n);
      int t;
      t = nw + n;
      cycles = 0;
      while (nw < t && cycles < 300) begin
         cyc();
         cycles++;
      end
      check("drain", 256'(nw), 256'(t));
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      for (int i = 0; i < N; i++) begin
         bn[i] = 0;
         bp[i] = 0;
         stall[i] = 1'b0;
      end
      exq.delete();
      lk_pend = 1'b0;
      i_fifo_full = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk);
      #1;
      drive();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         bn[i] = 0;
         bp[i] = 0;
         stall[i] = 1'b0;
      end
      // reset gating with a pending request that would win
      i_req_valid = 4'b0100;
      i_req_last  = '1;
      @(negedge clk);
      check("rst_write", 256'(o_fifo_write), 256'(0));
      check("rst_ready", 256'(o_req_ready), 256'(0));
      check("rst_grant", 256'(o_grant_id), 256'(0));
      check("rst_locked", 256'(o_locked), 256'(0));
      do_reset();
      repeat (10) begin
         @(negedge clk);
         check("idle_write", 256'(o_fifo_write), 256'(0));
         check("idle_ready", 256'(o_req_ready), 256'(0));
         check("idle_locked", 256'(o_locked), 256'(0));
         @(posedge clk);
         #1;
      end

      // fairness
      do_reset();
      for (int r = 0; r < N; r++) pkt(r, 1);
      for (int r = 0; r < N; r++) pkt(r, 1);
      for (int k = 0; k < 2; k++) for (int r = 0; r < N; r++) expect_beat(r, k, 1'b0);
      drive();
      run_writes(8);
      check("fair_cycles", 256'(cycles), 256'(8));
      check("fair_sb_left", 256'(exq.size()), 256'(0));

      // burst lock
      do_reset();
      pkt(1, 1);
      expect_beat(1, 0, 1'b0);
      drive();
      run_writes(1);
      pkt(2, 3);
      pkt(0, 1);
      expect_beat(2, 0, 1'b1);
      expect_beat(2, 1, 1'b1);
      expect_beat(2, 2, 1'b0);
      expect_beat(0, 0, 1'b0);
      drive();
      run_writes(4);
      check("lock_cycles", 256'(cycles), 256'(4));

      // burst cap
      pkt(1, 12);
      pkt(3, 1);
      for (int j = 0; j < 8; j++) expect_beat(1, 1 + j, j < MB - 1);
      expect_beat(3, 0, 1'b0);
      for (int j = 8; j < 12; j++) expect_beat(1, 1 + j, j < 11);
      drive();
      run_writes(13);
      check("cap_cycles", 256'(cycles), 256'(13));

      // backpressure inside a locked burst
      pkt(2, 6);
      for (int j = 0; j < 6; j++) expect_beat(2, 3 + j, j < 5);
      drive();
      run_writes(2);
      i_fifo_full = 1'b1;
      repeat (5) begin
         mon();
         check("bp_ready", 256'(o_req_ready), 256'(0));
         check("bp_write", 256'(o_fifo_write), 256'(1));
         check("bp_grant", 256'(o_grant_id), 256'(2));
         check("bp_locked", 256'(o_locked), 256'(1));
         @(posedge clk);
         #1;
         drive();
      end
      i_fifo_full = 1'b0;
      run_writes(4);
      check("bp_cycles", 256'(cycles), 256'(4));

      // owner stall
      pkt(3, 4);
      pkt(0, 1);
      pkt(1, 1);
      expect_beat(3, 1, 1'b1);
      expect_beat(3, 2, 1'b1);
      expect_beat(3, 3, 1'b1);
      expect_beat(3, 4, 1'b0);
      expect_beat(0, 1, 1'b0);
      expect_beat(1, 13, 1'b0);
      drive();
      run_writes(2);
      stall[3] = 1'b1;
      drive();
      repeat (3) begin
         mon();
         check("stall_write", 256'(o_fifo_write), 256'(0));
         check("stall_grant", 256'(o_grant_id), 256'(3));
         check("stall_locked", 256'(o_locked), 256'(1));
         @(posedge clk);
         #1;
         drive();
      end
      stall[3] = 1'b0;
      drive();
      run_writes(4);
      check("stall_sb_left", 256'(exq.size()), 256'(0));

      // asynchronous reset mid-burst, then requester 0 has priority
      do_reset();
      pkt(1, 4);
      expect_beat(1, 0, 1'b1);
      expect_beat(1, 1, 1'b1);
      drive();
      run_writes(2);
      rstn = 1'b0;
      #1;
      check("arst_locked", 256'(o_locked), 256'(0));
      check("arst_write", 256'(o_fifo_write), 256'(0));
      check("arst_ready", 256'(o_req_ready), 256'(0));
      do_reset();
      pkt(3, 1);
      pkt(0, 1);
      expect_beat(0, 0, 1'b0);
      expect_beat(3, 0, 1'b0);
      drive();
      run_writes(2);
      check("arst_sb_left", 256'(exq.size()), 256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
